// File: rtl/div.sv
// Multi-cycle restoring radix-2 divider for DIV/DIVU: one quotient bit per clock,
// result returned as {remainder, quotient} with remainder taking the dividend's sign.
module div #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {
        S_FREE,
        S_BYZERO,
        S_ON,
        S_END
    } state_t;

    state_t              state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [2*DATA_W:0]   work, work_d;
    logic [DATA_W-1:0]   divisor, divisor_d;
    logic                sign1, sign1_d;
    logic                sign2, sign2_d;
    logic                sgn, sgn_d;
    logic [2*DATA_W-1:0] result_d;
    logic                ready_d;

    logic [DATA_W-1:0]   abs1, abs2;
    logic [DATA_W:0]     diff;
    logic [DATA_W-1:0]   quo, rem;

    // Magnitudes are taken at start; all iterations then run unsigned.
    assign abs1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign abs2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

    // Upper W+1 bits hold twice the partial remainder plus the next dividend bit,
    // so diff's top bit is a reliable borrow even for divisors above 2^(W-1).
    assign diff = work[2*DATA_W:DATA_W] - {1'b0, divisor};
    assign quo  = work[DATA_W-1:0];
    assign rem  = work[2*DATA_W:DATA_W+1];

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        work_d    = work;
        divisor_d = divisor;
        sign1_d   = sign1;
        sign2_d   = sign2;
        sgn_d     = sgn;
        result_d  = result_o;
        ready_d   = ready_o;

        case (state)
            S_FREE: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (start_i && !annul_i) begin
                    sign1_d = opdata1_i[DATA_W-1];
                    sign2_d = opdata2_i[DATA_W-1];
                    sgn_d   = signed_div_i;
                    if (opdata2_i == '0) begin
                        state_d = S_BYZERO;
                    end else begin
                        state_d   = S_ON;
                        divisor_d = abs2;
                        work_d    = {{DATA_W{1'b0}}, abs1, 1'b0};
                        cnt_d     = '0;
                    end
                end
            end
            S_BYZERO: begin
                if (annul_i) begin
                    state_d = S_FREE;
                end else begin
                    state_d  = S_END;
                    result_d = '0;
                    ready_d  = 1'b1;
                end
            end
            S_ON: begin
                if (annul_i) begin
                    state_d  = S_FREE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end else if (cnt != CNT_W'(DATA_W)) begin
                    if (diff[DATA_W]) begin
                        work_d = work << 1;
                    end else begin
                        work_d = {diff[DATA_W-1:0], work[DATA_W-1:0], 1'b1};
                    end
                    cnt_d = cnt + 1'b1;
                end else begin
                    // Quotient sign is the XOR of operand signs; remainder follows the dividend.
                    result_d = {(sgn && sign1) ? -rem : rem,
                                (sgn && (sign1 ^ sign2)) ? -quo : quo};
                    ready_d  = 1'b1;
                    state_d  = S_END;
                end
            end
            S_END: begin
                if (!start_i) begin
                    state_d  = S_FREE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end
            default: begin
                state_d  = S_FREE;
                result_d = '0;
                ready_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FREE;
            cnt      <= '0;
            work     <= '0;
            divisor  <= '0;
            sign1    <= 1'b0;
            sign2    <= 1'b0;
            sgn      <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            work     <= work_d;
            divisor  <= divisor_d;
            sign1    <= sign1_d;
            sign2    <= sign2_d;
            sgn      <= sgn_d;
            result_o <= result_d;
            ready_o  <= ready_d;
        end
    end

endmodule
